// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 key-event transmit scheduler.
// Frame length depends on RS485_KEY_SCHED_CKSUM_EN (see rs485_key_sched).
package rs485_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLoad,
        StSend,
        StWaitHi,
        StWaitLo,
        StTail
    } state_t;

    localparam logic [7:0] DefaultHeader = 8'hA5;

    localparam int unsigned FrameLenPlain = 2;
    localparam int unsigned FrameLenCksum = 3;

    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic [7:0] hdr,
                                              input logic [3:0] key);
        case (idx)
            2'd0:    return hdr;
            2'd1:    return {4'h0, key};
            default: return hdr ^ {4'h0, key};
        endcase
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Depth x WIDTH synchronous FIFO with registered read data (valid the cycle after a pop).
// Push and pop may coincide at any fill level, including full.
module key_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LvlW-1:0]  level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_wr, do_rd;

    assign full_o    = (level_q == LvlW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = rd_data_q;

    always_comb begin
        do_rd     = rd_en_i && !empty_o;
        do_wr     = wr_en_i && (!full_o || do_rd);
        wr_ptr_d  = do_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d  = do_rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        rd_data_d = do_rd ? mem_q[rd_ptr_q] : rd_data_q;
        level_d   = level_q;
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/rs485_key_sched.sv
// Queues key events and sends each as a framed UART burst with RS485 driver-enable guards.
// Define RS485_KEY_SCHED_CKSUM_EN to append a HEADER^data checksum byte (3-byte frames).
module rs485_key_sched
    import rs485_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GUARD_CYC  = 50,
    parameter logic [7:0]  HEADER     = DefaultHeader
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_data_valid,
    input  logic [3:0] key_data,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       rs485_de,
    output logic       ovf,
    output logic [7:0] drop_cnt
);

`ifdef RS485_KEY_SCHED_CKSUM_EN
    localparam int unsigned FrameLen = FrameLenCksum;
`else
    localparam int unsigned FrameLen = FrameLenPlain;
`endif
    localparam logic [1:0]  LastIdx  = 2'(FrameLen - 1);
    // rs485_de is registered from the state, so LEAD holds one clock longer than TAIL.
    localparam logic [15:0] LeadLast = 16'(GUARD_CYC);
    localparam logic [15:0] TailLast = 16'(GUARD_CYC - 1);
    localparam int unsigned LvlW     = $clog2(FIFO_DEPTH) + 1;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  key_q, key_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        de_q, de_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [3:0]      fifo_rd_data;
    logic [LvlW-1:0] fifo_level_unused;

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_push),
        .wr_data_i (key_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level_unused)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        key_d     = key_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StLead;
                    cnt_d   = '0;
                end
            end
            StLead: begin
                if (cnt_q == LeadLast) state_d = StLoad;
                else                   cnt_d   = cnt_q + 16'd1;
            end
            StLoad: begin
                fifo_pop = 1'b1;
                idx_d    = '0;
                state_d  = StSend;
            end
            StSend: begin
                // Hold off the start strobe while the UART is still busy.
                if (!tx_busy) begin
                    if (idx_q == 2'd0) key_d = fifo_rd_data;
                    tx_data_d = frame_byte(idx_q, HEADER,
                                           (idx_q == 2'd0) ? fifo_rd_data : key_q);
                    tx_en_d   = 1'b1;
                    state_d   = StWaitHi;
                end
            end
            StWaitHi: begin
                if (tx_busy) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    if (idx_q != LastIdx) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StSend;
                    end else if (!fifo_empty) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StTail;
                        cnt_d   = '0;
                    end
                end
            end
            StTail: begin
                if (cnt_q == TailLast) state_d = StIdle;
                else                   cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase

        de_d       = (state_q != StIdle);
        fifo_push  = key_data_valid && (!fifo_full || fifo_pop);
        ovf_d      = key_data_valid && fifo_full && !fifo_pop;
        drop_cnt_d = (ovf_d && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            key_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            de_q       <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            de_q       <= de_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign rs485_de = de_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rs485_key_sched.sv
// Scoreboard bench for rs485_key_sched with GUARD_CYC=4 and a 10-clock-busy UART model.
module tb_rs485_key_sched;

    localparam int G = 4;
    localparam logic [7:0] Hdr = 8'hA5;
`ifdef RS485_KEY_SCHED_CKSUM_EN
    localparam int FL = 3;
`else
    localparam int FL = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_data_valid = 1'b0;
    logic [3:0] key_data = 4'h0;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       rs485_de;
    logic       ovf;
    logic [7:0] drop_cnt;

    rs485_key_sched #(
        .FIFO_DEPTH (4),
        .GUARD_CYC  (G),
        .HEADER     (Hdr)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_data_valid (key_data_valid),
        .key_data       (key_data),
        .tx_busy        (tx_busy),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .rs485_de       (rs485_de),
        .ovf            (ovf),
        .drop_cnt       (drop_cnt)
    );

    always #10 clk = ~clk;

    // UART model: busy for 10 clocks starting the clock after tx_en; hold forces busy.
    int   busy_left = 0;
    logic hold = 1'b0;
    always @(posedge clk) begin
        if (tx_en)              busy_left <= 10;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy = hold || (busy_left != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int en_cycs[$];
    int fall_cycs[$];
    int de_rises = 0, de_falls = 0, de_rise_cyc = 0, de_fall_cyc = 0;
    int ovf_pulses = 0, en_busy_viol = 0;
    logic prev_de = 1'b0, prev_busy = 1'b0;

    int n_assert = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        if (tx_en) begin
            obs_q.push_back(tx_data);
            en_cycs.push_back(cyc);
            if (tx_busy) en_busy_viol++;
        end
        if (rs485_de && !prev_de) begin de_rises++; de_rise_cyc = cyc; end
        if (!rs485_de && prev_de) begin de_falls++; de_fall_cyc = cyc; end
        if (prev_busy && !tx_busy) fall_cycs.push_back(cyc);
        if (ovf) ovf_pulses++;
        prev_de   = rs485_de;
        prev_busy = tx_busy;
    end

    task automatic clear_mon;
        @(posedge clk);
        obs_q.delete();
        en_cycs.delete();
        fall_cycs.delete();
        de_rises = 0; de_falls = 0; ovf_pulses = 0; en_busy_viol = 0;
    endtask

    // Caller is at a negedge; returns at the next negedge with the event sampled.
    task automatic send_event(input logic [3:0] k, input bit accept, output int ev);
        key_data_valid = 1'b1;
        key_data       = k;
        if (accept) begin
            exp_q.push_back(Hdr);
            exp_q.push_back({4'h0, k});
            if (FL == 3) exp_q.push_back(Hdr ^ {4'h0, k});
        end
        @(negedge clk);
        key_data_valid = 1'b0;
        ev = cyc;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (obs_q.size() >= n && !rs485_de) begin ok = 1'b1; break; end
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++; if (tx_en !== 1'b0)      begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        n_assert++; if (tx_data !== 8'h00)   begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_assert++; if (rs485_de !== 1'b0)   begin n_fail++; $display("FAIL reset_de: got %b want 0", rs485_de); end
        n_assert++; if (ovf !== 1'b0)        begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_assert++; if (drop_cnt !== 8'h00)  begin n_fail++; $display("FAIL reset_drop_cnt: got %h want 00", drop_cnt); end
        rst_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        n_assert++; if (de_rises != 0 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL reset_idle: got de_rises=%0d bytes=%0d want 0 0", de_rises, obs_q.size());
        end
    endtask

    task automatic test_single;
        int ev; bit ok; logic [7:0] e, o;
        clear_mon();
        @(negedge clk);
        send_event(4'b1110, 1'b1, ev);
        wait_done(FL, 400, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got done=0 want 1"); end
        n_assert++; if (de_rise_cyc != ev + 2) begin
            n_fail++; $display("FAIL single_de_rise: got cyc %0d want %0d", de_rise_cyc, ev + 2);
        end
        n_assert++; if (en_cycs.size() != FL || fall_cycs.size() != FL) begin
            n_fail++; $display("FAIL single_counts: got en=%0d falls=%0d want %0d", en_cycs.size(), fall_cycs.size(), FL);
        end else begin
            n_assert++; if (en_cycs[0] != de_rise_cyc + G + 2) begin
                n_fail++; $display("FAIL single_first_en: got cyc %0d want %0d", en_cycs[0], de_rise_cyc + G + 2);
            end
            n_assert++; if (en_cycs[1] != fall_cycs[0] + 2) begin
                n_fail++; $display("FAIL single_next_en: got cyc %0d want %0d", en_cycs[1], fall_cycs[0] + 2);
            end
            n_assert++; if (de_fall_cyc != fall_cycs[FL-1] + G + 2) begin
                n_fail++; $display("FAIL single_de_fall: got cyc %0d want %0d", de_fall_cyc, fall_cycs[FL-1] + G + 2);
            end
        end
        n_assert++; if (en_busy_viol != 0) begin n_fail++; $display("FAIL single_en_busy: got %0d want 0", en_busy_viol); end
        n_assert++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_assert++; if (o !== e) begin n_fail++; $display("FAIL single_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_two_events;
        int ev; bit ok; logic [7:0] e, o;
        clear_mon();
        @(negedge clk);
        send_event(4'h3, 1'b1, ev);
        repeat (2) @(negedge clk);
        send_event(4'hC, 1'b1, ev);
        wait_done(2 * FL, 600, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL two_timeout: got done=0 want 1"); end
        n_assert++; if (de_rises != 1 || de_falls != 1) begin
            n_fail++; $display("FAIL two_de_burst: got rises=%0d falls=%0d want 1 1", de_rises, de_falls);
        end
        n_assert++; if (obs_q.size() != 2 * FL) begin
            n_fail++; $display("FAIL two_len: got %0d want %0d", obs_q.size(), 2 * FL);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_assert++; if (o !== e) begin n_fail++; $display("FAIL two_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_push_on_pop;
        int ev; bit ok; logic [7:0] e, o; logic [7:0] d0;
        clear_mon();
        d0 = drop_cnt;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_event(4'(i + 1), 1'b1, ev);
        repeat (3) @(negedge clk);
        // Lands on the edge where LOAD pops the first entry out of the full queue.
        send_event(4'h5, 1'b1, ev);
        wait_done(5 * FL, 1500, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL pop_push_timeout: got done=0 want 1"); end
        n_assert++; if (ovf_pulses != 0) begin n_fail++; $display("FAIL pop_push_ovf: got %0d want 0", ovf_pulses); end
        n_assert++; if (drop_cnt !== d0) begin n_fail++; $display("FAIL pop_push_drop: got %h want %h", drop_cnt, d0); end
        n_assert++; if (obs_q.size() != 5 * FL) begin
            n_fail++; $display("FAIL pop_push_len: got %0d want %0d", obs_q.size(), 5 * FL);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_assert++; if (o !== e) begin n_fail++; $display("FAIL pop_push_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_overflow;
        int ev; bit ok; logic [7:0] e, o;
        clear_mon();
        @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 6; i++) send_event(4'(i + 6), (i < 4), ev);
        repeat (20) @(negedge clk);
        n_assert++; if (ovf_pulses != 2) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 2", ovf_pulses); end
        n_assert++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ovf_sent_while_busy: got %0d want 0", obs_q.size()); end
        hold = 1'b0;
        wait_done(4 * FL, 1500, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: got done=0 want 1"); end
        n_assert++; if (en_busy_viol != 0) begin n_fail++; $display("FAIL ovf_en_busy: got %0d want 0", en_busy_viol); end
        n_assert++; if (obs_q.size() != 4 * FL) begin
            n_fail++; $display("FAIL ovf_len: got %0d want %0d", obs_q.size(), 4 * FL);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_assert++; if (o !== e) begin n_fail++; $display("FAIL ovf_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_tail_push;
        int ev; bit ok, seen; logic [7:0] e, o;
        clear_mon();
        @(negedge clk);
        send_event(4'h9, 1'b1, ev);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (obs_q.size() >= FL) seen = 1'b1;
        end
        if (seen) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = tx_busy; end
            if (seen) begin
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = !tx_busy; end
            end
        end
        n_assert++; if (!seen) begin n_fail++; $display("FAIL tail_sync: got found=0 want 1"); end
        @(negedge clk);
        send_event(4'h7, 1'b1, ev);
        wait_done(2 * FL, 600, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL tail_timeout: got done=0 want 1"); end
        n_assert++; if (de_rises != 2 || de_falls != 2) begin
            n_fail++; $display("FAIL tail_de_bursts: got rises=%0d falls=%0d want 2 2", de_rises, de_falls);
        end
        n_assert++; if (obs_q.size() != 2 * FL) begin
            n_fail++; $display("FAIL tail_len: got %0d want %0d", obs_q.size(), 2 * FL);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_assert++; if (o !== e) begin n_fail++; $display("FAIL tail_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int ev; bit seen;
        clear_mon();
        @(negedge clk);
        send_event(4'h3, 1'b1, ev);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (obs_q.size() >= 2) seen = 1'b1;
        end
        n_assert++; if (!seen) begin n_fail++; $display("FAIL rstmid_sync: got found=0 want 1"); end
        rst_n = 1'b0;
        #1;
        n_assert++; if (rs485_de !== 1'b0)  begin n_fail++; $display("FAIL rstmid_de: got %b want 0", rs485_de); end
        n_assert++; if (tx_en !== 1'b0)     begin n_fail++; $display("FAIL rstmid_tx_en: got %b want 0", tx_en); end
        n_assert++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rstmid_drop_cnt: got %h want 00", drop_cnt); end
        n_assert++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        clear_mon();
        repeat (60) @(negedge clk);
        n_assert++; if (obs_q.size() != 0 || de_rises != 0) begin
            n_fail++; $display("FAIL rstmid_stale: got bytes=%0d de_rises=%0d want 0 0", obs_q.size(), de_rises);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_events();
        test_push_on_pop();
        test_overflow();
        test_tail_push();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
